main_mem_resp: RTL and testbench



---
 rtl/main_mem_resp.sv | 168 ++++++++++++++++
 tb/tb_main_mem_resp.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/main_mem_resp.sv
`default_nettype none
// ============================================================================
// Module      : main_mem_resp
// Description : Line-granular backing store for the L1 data cache refill port.
//               Accepts a fill (read) or writeback (write) request, waits
//               LATENCY cycles, then streams LINE_WORDS words, one per cycle,
//               and ends with a one-cycle ack.
// Ports       : clk, rst (async, active-high)
//               req/we/addr  - request from the cache, sampled in IDLE
//               wdata        - writeback word, consumed when wready=1
//               busy         - transaction in progress (WAIT/BURST/DONE)
//               rvalid/rdata - fill beat, rdata registered
//               wready       - writeback beat taken on this edge
//               ack          - one-cycle completion pulse
// Option      : MAIN_MEM_CRITICAL_WORD_FIRST_EN - fills start at the
//               requested word and wrap within the line.
// Revision    : 1.0 - initial release
// ============================================================================
module main_mem_resp #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              wready,
    output logic              ack
);

    localparam int c_offW  = $clog2(LINE_WORDS);
    localparam int c_depW  = $clog2(DEPTH);
    localparam int c_lineW = c_depW - c_offW;
    localparam int c_latW  = $clog2(LATENCY + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic                r_we;
    logic [c_lineW-1:0]  r_lineBase;
    logic [c_offW-1:0]   r_startOff;
    logic [c_offW-1:0]   r_beatCnt;
    logic [c_latW-1:0]   r_latCnt;
    logic [DATA_W-1:0]   r_rdata;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_accept;
    logic                w_rdLoad;
    logic [c_depW-1:0]   w_rdIdx;
    logic [c_offW-1:0]   w_reqStart;
    logic [c_offW-1:0]   w_curWord;
    logic                w_beatLast;
    logic                w_memWe;
    logic                w_unusedAddr;

    // Bits above the storage depth are ignored, so addresses simply wrap.
    assign w_unusedAddr = ^addr;

`ifdef MAIN_MEM_CRITICAL_WORD_FIRST_EN
    // Fills begin at the requested word; writebacks always begin at word 0.
    assign w_reqStart = we ? '0 : addr[c_offW-1:0];
`else
    assign w_reqStart = '0;
`endif

    // Offset arithmetic is c_offW bits wide, so it wraps inside the line.
    assign w_curWord  = r_startOff + r_beatCnt;
    assign w_beatLast = (r_beatCnt == c_offW'(LINE_WORDS - 1));
    assign w_memWe    = (r_state == BURST) && r_we;

    // Next state, plus the read address for the beat shown in the NEXT cycle:
    // rdata is a register, so each fill word is fetched one edge early.
    always_comb begin
        w_stateNext = r_state;
        w_accept    = 1'b0;
        w_rdLoad    = 1'b0;
        w_rdIdx     = {r_lineBase, w_curWord};
        case (r_state)
            IDLE: begin
                if (req) begin
                    w_accept    = 1'b1;
                    w_stateNext = (LATENCY == 0) ? BURST : WAIT;
                    w_rdLoad    = (LATENCY == 0) && !we;
                    w_rdIdx     = {addr[c_depW-1:c_offW], w_reqStart};
                end
            end
            WAIT: begin
                if (r_latCnt == c_latW'(1)) begin
                    w_stateNext = BURST;
                    w_rdLoad    = !r_we;
                end
            end
            BURST: begin
                if (w_beatLast) begin
                    w_stateNext = DONE;
                end else begin
                    w_rdLoad = !r_we;
                    w_rdIdx  = {r_lineBase, w_curWord + c_offW'(1)};
                end
            end
            DONE: begin
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_lineBase <= '0;
            r_startOff <= '0;
            r_beatCnt  <= '0;
            r_latCnt   <= '0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_stateNext;
            if (w_accept) begin
                r_we       <= we;
                r_lineBase <= addr[c_depW-1:c_offW];
                r_startOff <= w_reqStart;
                r_beatCnt  <= '0;
                r_latCnt   <= c_latW'(LATENCY);
            end
            if (r_state == WAIT) begin
                r_latCnt <= r_latCnt - c_latW'(1);
            end
            if (r_state == BURST) begin
                r_beatCnt <= r_beatCnt + c_offW'(1);
            end
            if (w_rdLoad) begin
                r_rdata <= r_mem[w_rdIdx];
            end
        end
    end

    // Storage has no reset; writes already taken survive an aborted burst.
    always_ff @(posedge clk) begin
        if (w_memWe) begin
            r_mem[{r_lineBase, w_curWord}] <= wdata;
        end
    end

    assign busy   = (r_state != IDLE);
    assign rvalid = (r_state == BURST) && !r_we;
    assign wready = w_memWe;
    assign ack    = (r_state == DONE);
    assign rdata  = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_main_mem_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_main_mem_resp
// Description : Directed self-checking bench for main_mem_resp with the
//               default parameters (LATENCY=3, LINE_WORDS=4, DEPTH=1024).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_main_mem_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        rvalid;
    logic [31:0] rdata;
    logic        wready;
    logic        ack;

    int nCompared   = 0;
    int nMismatched = 0;

    main_mem_resp dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .busy   (busy),
        .rvalid (rvalid),
        .rdata  (rdata),
        .wready (wready),
        .ack    (ack)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full writeback: 3 WAIT cycles, 4 wready beats, ack in cycle 8, idle in 9.
    task automatic writeLine(input logic [15:0] a, input logic [31:0] d0, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] d3);
        logic [31:0] d [4];
        d = '{d0, d1, d2, d3};
        req = 1'b1; we = 1'b1; addr = a;
        tick;
        req = 1'b0; we = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            chk("wb_wait_busy", {31'd0, busy}, 32'd1);
            chk("wb_wait_wready", {31'd0, wready}, 32'd0);
            tick;
        end
        for (int b = 0; b < 4; b++) begin
            chk("wb_beat_wready", {31'd0, wready}, 32'd1);
            chk("wb_beat_rvalid", {31'd0, rvalid}, 32'd0);
            wdata = d[b];
            tick;
        end
        chk("wb_ack", {31'd0, ack}, 32'd1);
        chk("wb_ack_busy", {31'd0, busy}, 32'd1);
        tick;
        chk("wb_after_ack", {31'd0, ack}, 32'd0);
        chk("wb_after_busy", {31'd0, busy}, 32'd0);
    endtask

    // Full fill: first rvalid in cycle 4, beats in cycles 4..7, ack in cycle 8.
    task automatic readLine(input logic [15:0] a, input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] e [4];
        e = '{e0, e1, e2, e3};
        req = 1'b1; we = 1'b0; addr = a;
        tick;
        req = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            chk("rd_wait_busy", {31'd0, busy}, 32'd1);
            chk("rd_wait_rvalid", {31'd0, rvalid}, 32'd0);
            tick;
        end
        for (int b = 0; b < 4; b++) begin
            chk("rd_beat_rvalid", {31'd0, rvalid}, 32'd1);
            chk("rd_beat_rdata", rdata, e[b]);
            tick;
        end
        chk("rd_ack", {31'd0, ack}, 32'd1);
        chk("rd_ack_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rd_hold_rdata", rdata, e[3]);
        tick;
        chk("rd_after_ack", {31'd0, ack}, 32'd0);
        chk("rd_after_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busyCnt;
        int ackCnt;

        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        tick;
        tick;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_wready", {31'd0, wready}, 32'd0);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        tick;

        // Writeback then fill of the same line.
        writeLine(16'h0010, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        readLine(16'h0010, 32'hA0, 32'hA1, 32'hA2, 32'hA3);

        // Unaligned fill request.
`ifdef MAIN_MEM_CRITICAL_WORD_FIRST_EN
        readLine(16'h0012, 32'hA2, 32'hA3, 32'hA0, 32'hA1);
`else
        readLine(16'h0012, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
`endif

        // Address wrap: 0x0410 aliases 0x0010 with 1024 words of storage.
        writeLine(16'h0410, 32'hB0, 32'hB1, 32'hB2, 32'hB3);
        readLine(16'h0010, 32'hB0, 32'hB1, 32'hB2, 32'hB3);

        // Request pulsed during BURST is ignored.
        req = 1'b1; we = 1'b0; addr = 16'h0010;
        busyCnt = 0; ackCnt = 0;
        for (int c = 1; c <= 20; c++) begin
            tick;
            req = (c == 5);
            if (busy) busyCnt++;
            if (ack) ackCnt++;
        end
        req = 1'b0;
        chk("ign_busy_cycles", busyCnt, 32'd8);
        chk("ign_ack_count", ackCnt, 32'd1);

        // Reset in the second WAIT cycle of a fill.
        req = 1'b1; we = 1'b0; addr = 16'h0410;
        tick;
        req = 1'b0;
        tick;
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_rvalid", {31'd0, rvalid}, 32'd0);
        chk("abort_wready", {31'd0, wready}, 32'd0);
        chk("abort_ack", {31'd0, ack}, 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        tick;
        rst = 1'b0;
        ackCnt = 0; busyCnt = 0;
        for (int c = 0; c < 8; c++) begin
            tick;
            if (ack) ackCnt++;
            if (busy) busyCnt++;
        end
        chk("abort_no_ack", ackCnt, 32'd0);
        chk("abort_no_busy", busyCnt, 32'd0);

        // Writeback aborted after two beats keeps the two words written.
        writeLine(16'h0020, 32'hD0, 32'hD1, 32'hD2, 32'hD3);
        req = 1'b1; we = 1'b1; addr = 16'h0020;
        tick;
        req = 1'b0; we = 1'b0;
        tick;
        tick;
        tick;
        chk("wbabort_wready0", {31'd0, wready}, 32'd1);
        wdata = 32'hC0;
        tick;
        wdata = 32'hC1;
        tick;
        wdata = 32'hC2;
        rst = 1'b1;
        #1;
        chk("wbabort_wready", {31'd0, wready}, 32'd0);
        chk("wbabort_busy", {31'd0, busy}, 32'd0);
        tick;
        rst = 1'b0;
        tick;
        readLine(16'h0020, 32'hC0, 32'hC1, 32'hD2, 32'hD3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire
